// File: rtl/imem_loader.sv
// imem_loader: receives a program as a stream of bytes over a valid/ready
// handshake. It packs each group of four bytes little-endian into a 32-bit
// word and writes the word into InstructionMemory at consecutive word-aligned
// addresses starting at BASE_ADDR. The CPU is held in reset until the whole
// program has been written.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid=1 and
// byte_ready=1. The source must hold byte_data stable while byte_valid=1 and
// the byte has not yet transferred. byte_ready is a registered output that
// depends only on loader state, never on byte_valid.
module imem_loader #(
   parameter int             BUS         = 32,
   parameter int             DEPTH_WORDS = 256,
   parameter logic [BUS-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int             CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [BUS-1:0]   mem_addr,
   output logic [BUS-1:0]   mem_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       byte_idx;
   logic [CNT_W-1:0] word_idx;
   logic [CNT_W-1:0] words_lat;
   logic             len_ok;
   logic [BUS-1:0]   word_addr;
   logic             byte_take;

   // A length is legal when it is non-zero and fits in the instruction memory.
   // The comparison runs at 32 bits so that a DEPTH_WORDS larger than the
   // num_words range cannot truncate.
   assign len_ok = (num_words != '0) && (32'(num_words) <= 32'(DEPTH_WORDS));

   // Byte address of the current word. The arithmetic wraps modulo 2^BUS.
   assign word_addr = BASE_ADDR + (BUS'(word_idx) << 2);

   // A byte transfers only while the loader is advertising ready.
   assign byte_take = byte_valid && byte_ready;

   assign state_dbg = state;

   // Load sequencer. All outputs are registered and updated with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         byte_idx   <= 2'd0;
         word_idx   <= '0;
         words_lat  <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         cpu_hold   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         // mem_we is a single-cycle pulse that is raised only on entry to WRITE.
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
                  if (len_ok) begin
                     words_lat  <= num_words;
                     byte_idx   <= 2'd0;
                     word_idx   <= '0;
                     error      <= 1'b0;
                     byte_ready <= 1'b1;
                     busy       <= 1'b1;
                     state      <= S_RECV;
                  end else begin
                     error      <= 1'b1;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     state      <= S_ERR;
                  end
               end
            end
            S_RECV: begin
               if (byte_take) begin
                  mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     byte_ready <= 1'b0;
                     mem_we     <= 1'b1;
                     mem_addr   <= word_addr;
                     state      <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (word_idx == words_lat - CNT_W'(1)) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
                  state    <= S_DONE;
               end else begin
                  word_idx   <= word_idx + CNT_W'(1);
                  byte_ready <= 1'b1;
                  state      <= S_RECV;
               end
            end
            default: begin
               byte_ready <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Two instances share the
// same stimulus: u_dut_a uses BASE_ADDR=0 and u_dut_b uses BASE_ADDR=0x100.
// Expected writes are queued when a load is issued, and a negedge monitor
// pops and compares them whenever either instance pulses mem_we.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] num_words;
   logic        byte_valid;
   logic [7:0]  byte_data;

   logic        byte_ready_a, mem_we_a, cpu_hold_a, busy_a, done_a, error_a;
   logic [31:0] mem_addr_a, mem_wdata_a;
   logic [2:0]  state_dbg_a;
   logic        byte_ready_b, mem_we_b, cpu_hold_b, busy_b, done_b, error_b;
   logic [31:0] mem_addr_b, mem_wdata_b;
   logic [2:0]  state_dbg_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int wr_a  = 0;
   int wr_b  = 0;
   int c0;

   logic [63:0] exp_a_q[$];
   logic [63:0] exp_b_q[$];

   imem_loader #(.BASE_ADDR(32'h0000_0000)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .error(error_a),
      .state_dbg(state_dbg_a)
   );

   imem_loader #(.BASE_ADDR(32'h0000_0100)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .error(error_b),
      .state_dbg(state_dbg_b)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every write pulse must match the head of its queue
   always @(negedge clk) begin
      logic [63:0] e;
      if (mem_we_a === 1'b1) begin
         wr_a++;
         if (exp_a_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_a: unexpected write addr %h data %h", mem_addr_a, mem_wdata_a);
         end else begin
            e = exp_a_q.pop_front();
            chk("write_a_addr", mem_addr_a, e[63:32]);
            chk("write_a_data", mem_wdata_a, e[31:0]);
         end
      end
      if (mem_we_b === 1'b1) begin
         wr_b++;
         if (exp_b_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_b: unexpected write addr %h data %h", mem_addr_b, mem_wdata_b);
         end else begin
            e = exp_b_q.pop_front();
            chk("write_b_addr", mem_addr_b, e[63:32]);
            chk("write_b_data", mem_wdata_b, e[31:0]);
         end
      end
   end

   // driver tasks: every input change happens 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int idx, input logic [31:0] data);
      exp_a_q.push_back({32'h0000_0000 + 32'(idx) * 32'd4, data});
      exp_b_q.push_back({32'h0000_0100 + 32'(idx) * 32'd4, data});
   endtask

   task automatic pulse_start(input logic [15:0] n);
      start     = 1'b1;
      num_words = n;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input logic poke);
      byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         byte_data = 8'hEE;
         tick();
      end
      byte_valid = 1'b1;
      byte_data  = b;
      if (poke) begin
         start     = 1'b1;
         num_words = 16'd5;
      end
      for (int w = 0; w < 50; w++) begin
         if (byte_ready_a === 1'b1) begin
            tick();
            start      = 1'b0;
            byte_valid = 1'b0;
            return;
         end
         tick();
         start = 1'b0;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept: byte %h not taken, byte_ready %b required 1", b, byte_ready_a);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input logic poke);
      send_byte(w[7:0], gap, 1'b0);
      send_byte(w[15:8], gap, poke);
      send_byte(w[23:16], gap, 1'b0);
      send_byte(w[31:24], gap, 1'b0);
   endtask

   task automatic wait_done(input string name, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (done_a === 1'b1) break;
         tick();
      end
      chk(name, {31'd0, done_a}, 32'd1);
      chk({name, "_b"}, {31'd0, done_b}, 32'd1);
   endtask

   task automatic drained(input string name, input int n);
      chk({name, "_qa"}, exp_a_q.size(), 32'd0);
      chk({name, "_qb"}, exp_b_q.size(), 32'd0);
      chk({name, "_nwr_a"}, wr_a, n);
      chk({name, "_nwr_b"}, wr_b, n);
      wr_a = 0;
      wr_b = 0;
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_ready"}, {31'd0, byte_ready_a}, 32'd0);
      chk({name, "_we"}, {31'd0, mem_we_a}, 32'd0);
      chk({name, "_addr_a"}, mem_addr_a, 32'h0000_0000);
      chk({name, "_addr_b"}, mem_addr_b, 32'h0000_0100);
      chk({name, "_wdata"}, mem_wdata_a, 32'd0);
      chk({name, "_hold"}, {31'd0, cpu_hold_a}, 32'd1);
      chk({name, "_busy"}, {31'd0, busy_a}, 32'd0);
      chk({name, "_done"}, {31'd0, done_a}, 32'd0);
      chk({name, "_error"}, {31'd0, error_a}, 32'd0);
      chk({name, "_state"}, {29'd0, state_dbg_a}, 32'd0);
      chk({name, "_busy_b"}, {31'd0, busy_b}, 32'd0);
   endtask

   // watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      num_words  = 16'd0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (3) tick();
      chk_reset_vals("rst0");
      reset = 1'b1;
      tick();

      // single word, latency check
      push_word(0, 32'h0050_0513);
      c0 = cyc;
      pulse_start(16'd1);
      chk("t1_ready", {31'd0, byte_ready_a}, 32'd1);
      send_byte(8'h13, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'h50, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      wait_done("t1_done", 20);
      chk("t1_latency", cyc - c0, 32'd6);
      chk("t1_hold", {31'd0, cpu_hold_a}, 32'd0);
      chk("t1_busy", {31'd0, busy_a}, 32'd0);
      drained("t1", 1);

      // three words, restarted from DONE
      push_word(0, 32'h1111_1111);
      push_word(1, 32'h2222_2222);
      push_word(2, 32'h3333_3333);
      pulse_start(16'd3);
      chk("t2_done_clr", {31'd0, done_a}, 32'd0);
      chk("t2_busy", {31'd0, busy_a}, 32'd1);
      chk("t2_hold", {31'd0, cpu_hold_a}, 32'd1);
      send_word(32'h1111_1111, 0, 1'b0);
      send_word(32'h2222_2222, 0, 1'b0);
      send_word(32'h3333_3333, 0, 1'b0);
      wait_done("t2_done", 20);
      drained("t2", 3);

      // stalled source: valid pattern 1,0,0,1,0,0,...
      push_word(0, 32'hA1B2_C3D4);
      push_word(1, 32'h0F1E_2D3C);
      pulse_start(16'd2);
      send_word(32'hA1B2_C3D4, 2, 1'b0);
      send_word(32'h0F1E_2D3C, 2, 1'b0);
      wait_done("t3_done", 40);
      drained("t3", 2);

      // length errors
      pulse_start(16'd0);
      chk("t4_err0", {31'd0, error_a}, 32'd1);
      chk("t4_done_clr", {31'd0, done_a}, 32'd0);
      chk("t4_hold0", {31'd0, cpu_hold_a}, 32'd1);
      chk("t4_ready0", {31'd0, byte_ready_a}, 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      repeat (5) tick();
      byte_valid = 1'b0;
      chk("t4_state", {29'd0, state_dbg_a}, 32'd4);
      pulse_start(16'd257);
      chk("t4_err257", {31'd0, error_a}, 32'd1);
      chk("t4_hold257", {31'd0, cpu_hold_a}, 32'd1);
      chk("t4_busy257", {31'd0, busy_a}, 32'd0);
      drained("t4_err", 0);
      push_word(0, 32'hDEAD_BEEF);
      pulse_start(16'd1);
      chk("t4_err_clr", {31'd0, error_a}, 32'd0);
      chk("t4_busy", {31'd0, busy_a}, 32'd1);
      send_word(32'hDEAD_BEEF, 0, 1'b0);
      wait_done("t4_done", 20);
      drained("t4", 1);

      // reset in the middle of a load
      pulse_start(16'd2);
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'h03;
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("t5_async");
      repeat (3) tick();
      byte_valid = 1'b0;
      drained("t5_abort", 0);
      reset = 1'b1;
      tick();
      push_word(0, 32'hCAFE_F00D);
      pulse_start(16'd1);
      send_word(32'hCAFE_F00D, 0, 1'b0);
      wait_done("t5_done", 20);
      drained("t5", 1);

      // start pulsed while receiving is ignored
      push_word(0, 32'h8765_4321);
      push_word(1, 32'h0BAD_F00D);
      pulse_start(16'd2);
      send_word(32'h8765_4321, 0, 1'b1);
      chk("t6_busy", {31'd0, busy_a}, 32'd1);
      send_word(32'h0BAD_F00D, 0, 1'b0);
      wait_done("t6_done", 20);
      chk("t6_hold", {31'd0, cpu_hold_a}, 32'd0);
      drained("t6", 2);

      // full-depth load: last word lands at BASE_ADDR + 0x3FC
      for (int i = 0; i < 256; i++) push_word(i, 32'h1000_0000 | 32'(i));
      pulse_start(16'd256);
      chk("t7_accept", {31'd0, busy_a}, 32'd1);
      for (int i = 0; i < 256; i++) send_word(32'h1000_0000 | 32'(i), 0, 1'b0);
      wait_done("t7_done", 20);
      chk("t7_last_addr_a", mem_addr_a, 32'h0000_03FC);
      chk("t7_last_addr_b", mem_addr_b, 32'h0000_04FC);
      drained("t7", 256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch path. It accepts a program as a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words.
- It writes each word into InstructionMemory at consecutive word-aligned byte addresses.
- It holds the CPU in reset until the whole program is written. It sits between a host/debug byte source and the InstructionMemory write port, alongside Program_Counter.

Parameters:
- BUS, 32, data and address width; fixed at 32 for this design
- DEPTH_WORDS, 256, instruction memory capacity in words
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned
- CNT_W, 16, width of num_words input

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- num_words  input  CNT_W  program length in words; sampled on accepted start
- byte_valid  input  1  source has a byte on byte_data
- byte_data  input  8  program byte
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  BUS  byte address of write (BASE_ADDR + 4*word_idx)
- mem_wdata  output  BUS  assembled instruction word
- cpu_hold  output  1  1 = hold CPU/Program_Counter in reset
- busy  output  1  load in progress (RECV or WRITE)
- done  output  1  level; program fully written
- error  output  1  level; rejected length

Behaviour:
- Reset (reset=0, async): state=IDLE. byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0. Internal byte_idx=0, word_idx=0.
- Reset asserted mid-load aborts the load immediately. No further mem_we is issued, and already-written words are not rolled back.
- States and transitions:
  - IDLE: cpu_hold=1.
    - start with 1 <= num_words <= DEPTH_WORDS: latch num_words, clear byte_idx and word_idx, go to RECV.
    - start with num_words=0 or num_words > DEPTH_WORDS: go to ERR.
  - RECV: byte_ready=1, busy=1.
    - Handshake: a byte transfers on a clk edge with byte_valid=1 and byte_ready=1. byte_idx=k writes mem_wdata[8k+7:8k]; the first byte lands in [7:0].
    - byte_idx increments and wraps 3->0.
    - On the 4th accepted byte, go to WRITE.
    - byte_valid=0 stalls indefinitely with no timeout.
  - WRITE: exactly one cycle. byte_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*word_idx, mem_wdata holds the full word, busy=1.
    - Next state is DONE if word_idx==num_words-1; otherwise word_idx+1 and RECV.
  - DONE: done=1, cpu_hold=0, busy=0, byte_ready=0. Stays here until start.
  - ERR: error=1, cpu_hold=1, busy=0. Stays here until start.
- start from DONE or ERR clears done/error on the transition edge and follows the same rules as IDLE.
- start while busy is ignored.
- Bytes presented while byte_ready=0 are not consumed.
- Latency:
  - start at edge t puts RECV in effect after t, so byte_ready=1 in cycle t+1.
  - Best case is 5 cycles per word: 4 byte cycles plus 1 write cycle.
  - For N words with a byte offered every cycle, done rises 5N+1 cycles after start.
- mem_addr arithmetic is modulo 2^BUS. word_idx never exceeds DEPTH_WORDS-1 because of the length check.
- All outputs are registered. There is no combinational path from byte_valid to byte_ready.

Test Plan:
- Single word: reset, then start with num_words=1, then bytes 0x13,0x05,0x50,0x00 on consecutive cycles. Required: one mem_we with addr=0x0 and wdata=0x00500513; then done=1 and cpu_hold=0, with done 6 cycles after start.
- Three words with BASE_ADDR=0x100: words 0x11111111, 0x22222222, 0x33333333. Required: mem_we at 0x100, 0x104, 0x108 with matching data and exactly 3 write pulses.
- Stall: byte_valid toggled 1,0,0,1,... during a 2-word load. Required: byte order is preserved, no byte is lost or duplicated, and mem_wdata is correct.
- Length errors:
  - num_words=0: error=1, no mem_we, cpu_hold=1.
  - num_words=257 with DEPTH_WORDS=256: error=1, no mem_we, cpu_hold=1.
  - A following start with num_words=1 clears error and loads normally.
- Reset mid-load: reset=0 after 2 bytes of word 1 of a 2-word load. Required: outputs return to reset values asynchronously, with no further mem_we. A new load then writes from BASE_ADDR.
- Ignored start: pulse start with num_words=5 while in RECV of a 2-word load. Required: the load completes after 2 words and done=1.
